// File: rtl/pipe_pkg.sv
// Shared widths, control-bundle layout and the WB-to-ID bypass match used
// by the decode-stage pipeline register.
package pipe_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_RA_W = 5;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [4:0] bu_op;
        logic [2:0] dm_ctrl;
        logic [1:0] write_src;
        logic       alu_a_src;
        logic       alu_b_src;
    } ctrl_t;

    localparam int DEF_CTRL_W = $bits(ctrl_t);

    // x0 is hard-wired zero, so a writeback to it must never be forwarded.
    function automatic logic is_bypass(input logic [DEF_RA_W-1:0] rd,
                                       input logic [DEF_RA_W-1:0] rs,
                                       input logic                we);
        return we && (rd == rs) && (rd != '0);
    endfunction

endpackage

// File: rtl/decode_stage_pipe_hazard.sv
// Load-use interlock: detects a consumer of the load sitting in EX and
// keeps decode frozen for the configured number of bubbles.
module hazard_unit
    import pipe_pkg::*;
#(
    parameter int RA_W       = DEF_RA_W,
    parameter int LU_BUBBLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_ex_i,
    input  logic            mem_rd_ex_i,
    input  logic [RA_W-1:0] rd_ex_i,
    input  logic            valid_de_i,
    input  logic            use_rs1_i,
    input  logic            use_rs2_i,
    input  logic [RA_W-1:0] rs1_i,
    input  logic [RA_W-1:0] rs2_i,
    input  logic            hold_ex_i,
    input  logic            flush_i,
    output logic            lu_hit_o,
    output logic            busy_o,
    output logic            stall_fd_o
);

    logic [1:0] cnt_q, cnt_d;

    assign lu_hit_o = valid_ex_i && mem_rd_ex_i && (rd_ex_i != '0) && valid_de_i &&
                      ((use_rs1_i && (rs1_i == rd_ex_i)) ||
                       (use_rs2_i && (rs2_i == rd_ex_i)));

    assign busy_o     = (cnt_q != 2'd0);
    assign stall_fd_o = hold_ex_i || (lu_hit_o && !flush_i) || busy_o;

    // The hit cycle itself is the first bubble; the counter covers the rest.
    always_comb begin
        cnt_d = cnt_q;
        if (flush_i)
            cnt_d = 2'd0;
        else if (hold_ex_i)
            cnt_d = cnt_q;
        else if (busy_o)
            cnt_d = cnt_q - 2'd1;
        else if (lu_hit_o)
            cnt_d = 2'(LU_BUBBLES - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 2'd0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// ID/EX pipeline register with WB bypass, flush/hold, load-use bubbles
// and a saturating count of interlock stall cycles.
module decode_stage_pipe
    import pipe_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int RA_W       = DEF_RA_W,
    parameter int CTRL_W     = DEF_CTRL_W,
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_de,
    input  logic [XLEN-1:0]   pc_de,
    input  logic [XLEN-1:0]   pc_next_de,
    input  logic [RA_W-1:0]   rs1_de,
    input  logic [RA_W-1:0]   rs2_de,
    input  logic [RA_W-1:0]   rd_de,
    input  logic              use_rs1_de,
    input  logic              use_rs2_de,
    input  logic [XLEN-1:0]   ru_rs1_de,
    input  logic [XLEN-1:0]   ru_rs2_de,
    input  logic [XLEN-1:0]   imm_de,
    input  logic [CTRL_W-1:0] ctrl_de,
    input  logic              ru_write_de,
    input  logic              dm_wr_de,
    input  logic              mem_rd_de,
    input  logic [XLEN-1:0]   dw_wb,
    input  logic [RA_W-1:0]   rd_wb,
    input  logic              ru_we_wb,
    input  logic              hold_ex,
    input  logic              flush,
    output logic              valid_ex,
    output logic [XLEN-1:0]   pc_ex,
    output logic [XLEN-1:0]   pc_next_ex,
    output logic [XLEN-1:0]   rs1_data_ex,
    output logic [XLEN-1:0]   rs2_data_ex,
    output logic [XLEN-1:0]   imm_ex,
    output logic [RA_W-1:0]   rs1_ex,
    output logic [RA_W-1:0]   rs2_ex,
    output logic [RA_W-1:0]   rd_ex,
    output logic [CTRL_W-1:0] ctrl_ex,
    output logic              ru_write_ex,
    output logic              dm_wr_ex,
    output logic              mem_rd_ex,
    output logic              stall_fd,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d, pcn_q, pcn_d, rs1d_q, rs1d_d, rs2d_q, rs2d_d, imm_q, imm_d;
    logic [RA_W-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              rw_q, rw_d, dw_q, dw_d, mr_q, mr_d;
    logic [CNT_W-1:0]  scnt_q, scnt_d;
    logic [XLEN-1:0]   rs1_byp, rs2_byp;
    logic              lu_hit, busy;

    assign rs1_byp = is_bypass(rd_wb, rs1_de, ru_we_wb) ? dw_wb : ru_rs1_de;
    assign rs2_byp = is_bypass(rd_wb, rs2_de, ru_we_wb) ? dw_wb : ru_rs2_de;

    hazard_unit #(.RA_W(RA_W), .LU_BUBBLES(LU_BUBBLES)) u_hazard (
        .clk        (clk),
        .rst        (rst),
        .valid_ex_i (valid_q),
        .mem_rd_ex_i(mr_q),
        .rd_ex_i    (rd_q),
        .valid_de_i (valid_de),
        .use_rs1_i  (use_rs1_de),
        .use_rs2_i  (use_rs2_de),
        .rs1_i      (rs1_de),
        .rs2_i      (rs2_de),
        .hold_ex_i  (hold_ex),
        .flush_i    (flush),
        .lu_hit_o   (lu_hit),
        .busy_o     (busy),
        .stall_fd_o (stall_fd)
    );

    always_comb begin
        valid_d = valid_q; pc_d = pc_q; pcn_d = pcn_q; rs1d_d = rs1d_q; rs2d_d = rs2d_q;
        imm_d = imm_q; rs1_d = rs1_q; rs2_d = rs2_q; rd_d = rd_q; ctrl_d = ctrl_q;
        rw_d = rw_q; dw_d = dw_q; mr_d = mr_q;
        if (flush) begin
            valid_d = 1'b0; pc_d = '0; pcn_d = '0; rs1d_d = '0; rs2d_d = '0;
            imm_d = '0; rs1_d = '0; rs2_d = '0; rd_d = '0; ctrl_d = '0;
            rw_d = 1'b0; dw_d = 1'b0; mr_d = 1'b0;
        end else if (hold_ex) begin
            valid_d = valid_q;
        end else if (lu_hit || busy) begin
            // Bubble: data fields are left stale, only validity and flags drop.
            valid_d = 1'b0; rw_d = 1'b0; dw_d = 1'b0; mr_d = 1'b0;
        end else begin
            valid_d = valid_de; pc_d = pc_de; pcn_d = pc_next_de;
            rs1d_d = rs1_byp; rs2d_d = rs2_byp; imm_d = imm_de;
            rs1_d = rs1_de; rs2_d = rs2_de; rd_d = rd_de; ctrl_d = ctrl_de;
            rw_d = ru_write_de && valid_de;
            dw_d = dm_wr_de && valid_de;
            mr_d = mem_rd_de && valid_de;
        end
    end

    always_comb begin
        scnt_d = scnt_q;
        if ((lu_hit || busy) && !flush && (scnt_q != '1))
            scnt_d = scnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0; pc_q <= '0; pcn_q <= '0; rs1d_q <= '0; rs2d_q <= '0;
            imm_q <= '0; rs1_q <= '0; rs2_q <= '0; rd_q <= '0; ctrl_q <= '0;
            rw_q <= 1'b0; dw_q <= 1'b0; mr_q <= 1'b0; scnt_q <= '0;
        end else begin
            valid_q <= valid_d; pc_q <= pc_d; pcn_q <= pcn_d; rs1d_q <= rs1d_d;
            rs2d_q <= rs2d_d; imm_q <= imm_d; rs1_q <= rs1_d; rs2_q <= rs2_d;
            rd_q <= rd_d; ctrl_q <= ctrl_d; rw_q <= rw_d; dw_q <= dw_d;
            mr_q <= mr_d; scnt_q <= scnt_d;
        end
    end

    assign valid_ex    = valid_q;
    assign pc_ex       = pc_q;
    assign pc_next_ex  = pcn_q;
    assign rs1_data_ex = rs1d_q;
    assign rs2_data_ex = rs2d_q;
    assign imm_ex      = imm_q;
    assign rs1_ex      = rs1_q;
    assign rs2_ex      = rs2_q;
    assign rd_ex       = rd_q;
    assign ctrl_ex     = ctrl_q;
    assign ru_write_ex = rw_q;
    assign dm_wr_ex    = dw_q;
    assign mem_rd_ex   = mr_q;
    assign stall_cnt   = scnt_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: one instance with a single load-use bubble and
// 16-bit counter, one with two bubbles and a 4-bit counter, on shared inputs.
module tb_decode_stage_pipe;

    logic        clk = 1'b0, rst = 1'b1;
    logic        valid_de, use_rs1_de, use_rs2_de, ru_write_de, dm_wr_de, mem_rd_de;
    logic [31:0] pc_de, pc_next_de, ru_rs1_de, ru_rs2_de, imm_de, dw_wb;
    logic [4:0]  rs1_de, rs2_de, rd_de, rd_wb;
    logic [15:0] ctrl_de;
    logic        ru_we_wb, hold_ex, flush;

    logic        a_valid, a_rw, a_dw, a_mr, a_stall;
    logic [31:0] a_pc, a_pcn, a_d1, a_d2, a_imm;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [15:0] a_ctrl, a_cnt;
    logic        b_valid, b_rw, b_dw, b_mr, b_stall;
    logic [31:0] b_pc, b_pcn, b_d1, b_d2, b_imm;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [15:0] b_ctrl;
    logic [3:0]  b_cnt;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    decode_stage_pipe #(.LU_BUBBLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .valid_de(valid_de), .pc_de(pc_de), .pc_next_de(pc_next_de),
        .rs1_de(rs1_de), .rs2_de(rs2_de), .rd_de(rd_de), .use_rs1_de(use_rs1_de),
        .use_rs2_de(use_rs2_de), .ru_rs1_de(ru_rs1_de), .ru_rs2_de(ru_rs2_de), .imm_de(imm_de),
        .ctrl_de(ctrl_de), .ru_write_de(ru_write_de), .dm_wr_de(dm_wr_de), .mem_rd_de(mem_rd_de),
        .dw_wb(dw_wb), .rd_wb(rd_wb), .ru_we_wb(ru_we_wb), .hold_ex(hold_ex), .flush(flush),
        .valid_ex(a_valid), .pc_ex(a_pc), .pc_next_ex(a_pcn), .rs1_data_ex(a_d1),
        .rs2_data_ex(a_d2), .imm_ex(a_imm), .rs1_ex(a_rs1), .rs2_ex(a_rs2), .rd_ex(a_rd),
        .ctrl_ex(a_ctrl), .ru_write_ex(a_rw), .dm_wr_ex(a_dw), .mem_rd_ex(a_mr),
        .stall_fd(a_stall), .stall_cnt(a_cnt));

    decode_stage_pipe #(.LU_BUBBLES(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .valid_de(valid_de), .pc_de(pc_de), .pc_next_de(pc_next_de),
        .rs1_de(rs1_de), .rs2_de(rs2_de), .rd_de(rd_de), .use_rs1_de(use_rs1_de),
        .use_rs2_de(use_rs2_de), .ru_rs1_de(ru_rs1_de), .ru_rs2_de(ru_rs2_de), .imm_de(imm_de),
        .ctrl_de(ctrl_de), .ru_write_de(ru_write_de), .dm_wr_de(dm_wr_de), .mem_rd_de(mem_rd_de),
        .dw_wb(dw_wb), .rd_wb(rd_wb), .ru_we_wb(ru_we_wb), .hold_ex(hold_ex), .flush(flush),
        .valid_ex(b_valid), .pc_ex(b_pc), .pc_next_ex(b_pcn), .rs1_data_ex(b_d1),
        .rs2_data_ex(b_d2), .imm_ex(b_imm), .rs1_ex(b_rs1), .rs2_ex(b_rs2), .rd_ex(b_rd),
        .ctrl_ex(b_ctrl), .ru_write_ex(b_rw), .dm_wr_ex(b_dw), .mem_rd_ex(b_mr),
        .stall_fd(b_stall), .stall_cnt(b_cnt));

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2;
        logic [31:0] r1, r2;
        logic [2:0]  fl;      // {ru_write, dm_wr, mem_rd}
        logic [31:0] wdat;
        logic [4:0]  rdwb;
        logic        wewb;
        logic        ev;
        logic [31:0] ed1, ed2;
        logic [2:0]  efl;
    } vec_t;

    typedef struct {
        logic        v;
        logic [31:0] pc, d1, d2;
        logic [4:0]  rs1, rd;
        logic [2:0]  fl;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        valid_de = 0; pc_de = 0; pc_next_de = 0; rs1_de = 0; rs2_de = 0; rd_de = 0;
        use_rs1_de = 0; use_rs2_de = 0; ru_rs1_de = 0; ru_rs2_de = 0; imm_de = 0;
        ctrl_de = 0; ru_write_de = 0; dm_wr_de = 0; mem_rd_de = 0;
        dw_wb = 0; rd_wb = 0; ru_we_wb = 0; hold_ex = 0; flush = 0;
    endtask

    task automatic drive_vec(input vec_t v);
        idle();
        valid_de = v.v; pc_de = v.pc; pc_next_de = v.pc + 4;
        rs1_de = v.rs1; rs2_de = v.rs2; rd_de = v.rd; use_rs1_de = v.u1; use_rs2_de = v.u2;
        ru_rs1_de = v.r1; ru_rs2_de = v.r2; {ru_write_de, dm_wr_de, mem_rd_de} = v.fl;
        dw_wb = v.wdat; rd_wb = v.rdwb; ru_we_wb = v.wewb;
    endtask

    task automatic drive_load(input logic [4:0] rd);
        idle();
        valid_de = 1; pc_de = 32'h200; rd_de = rd; ru_write_de = 1; mem_rd_de = 1;
    endtask

    task automatic drive_use(input logic [4:0] rs, input logic via_rs2);
        idle();
        valid_de = 1; pc_de = 32'h204; rd_de = 5'd8; ru_write_de = 1;
        rs1_de = via_rs2 ? 5'd1 : rs; use_rs1_de = 1;
        rs2_de = via_rs2 ? rs : 5'd2; use_rs2_de = via_rs2;
        ru_rs2_de = 32'h77;
    endtask

    initial begin
        exp_t e;
        vecs[0] = '{1, 'h100, 3, 4, 6, 1, 1, 'h11, 'h22, 3'b100, 0, 0, 0, 1, 'h11, 'h22, 3'b100};
        vecs[1] = '{1, 'h104, 5, 9, 10, 1, 1, 0, 'h99, 3'b100, 'hDEADBEEF, 5, 1, 1, 'hDEADBEEF, 'h99, 3'b100};
        vecs[2] = '{1, 'h108, 0, 2, 11, 1, 1, 'hA5, 'h2, 3'b100, 'h12345678, 0, 1, 1, 'hA5, 'h2, 3'b100};
        vecs[3] = '{1, 'h10C, 1, 4, 12, 1, 1, 'h1, 'h44, 3'b010, 'h55, 4, 0, 1, 'h1, 'h44, 3'b010};
        vecs[4] = '{1, 'h110, 8, 8, 13, 1, 1, 'h3, 'h4, 3'b100, 'hCAFE0000, 8, 1, 1, 'hCAFE0000, 'hCAFE0000, 3'b100};
        vecs[5] = '{0, 'h114, 2, 3, 14, 1, 1, 'h7, 'h8, 3'b111, 0, 0, 0, 0, 'h7, 'h8, 3'b000};
        vecs[6] = '{1, 'h118, 6, 7, 15, 0, 0, 'h61, 'h71, 3'b100, 'h99, 7, 1, 1, 'h61, 'h99, 3'b100};

        idle();
        #1;
        chk("rst_valid", a_valid, 0);
        chk("rst_cnt", a_cnt, 0);

        // Capture, then reset mid-cycle: outputs must clear without an edge.
        @(negedge clk); rst = 0; valid_de = 1; pc_de = 32'h40; ru_write_de = 1;
        @(posedge clk); #1;
        chk("pre_rst_pc", a_pc, 32'h40);
        #2 rst = 1; #1;
        chk("async_valid", a_valid, 0);
        chk("async_pc", a_pc, 0);
        chk("async_rw", a_rw, 0);
        chk("async_cnt", a_cnt, 0);
        chk("async_stall", a_stall, 0);
        @(negedge clk); rst = 0;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive_vec(vecs[i]);
            sb.push_back('{vecs[i].ev, vecs[i].pc, vecs[i].ed1, vecs[i].ed2,
                           vecs[i].rs1, vecs[i].rd, vecs[i].efl});
            #1 chk($sformatf("v%0d_stall", i), a_stall, 0);
            @(posedge clk); #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_valid", i), a_valid, e.v);
            chk($sformatf("v%0d_pc", i), a_pc, e.pc);
            chk($sformatf("v%0d_rs1", i), a_rs1, e.rs1);
            chk($sformatf("v%0d_rd", i), a_rd, e.rd);
            chk($sformatf("v%0d_d1", i), a_d1, e.d1);
            chk($sformatf("v%0d_d2", i), a_d2, e.d2);
            chk($sformatf("v%0d_flags", i), {a_rw, a_dw, a_mr}, e.fl);
        end
        chk("sb_empty", sb.size(), 0);

        // Hold: registers freeze, no counting.
        @(negedge clk); drive_vec(vecs[0]); hold_ex = 1;
        #1 chk("hold_stall", a_stall, 1);
        @(posedge clk); #1;
        chk("hold_pc", a_pc, 32'h118);
        chk("hold_valid", a_valid, 1);
        chk("hold_cnt", a_cnt, 0);

        // Load-use via rs2: one bubble on A, two on B.
        @(negedge clk); drive_load(5'd7);
        @(posedge clk);
        @(negedge clk); drive_use(5'd7, 1'b1);
        #1 chk("lu_stall_a", a_stall, 1);
        chk("lu_stall_b", b_stall, 1);
        @(posedge clk); #1;
        chk("lu_bub1_a", a_valid, 0);
        chk("lu_bub1_mr", a_mr, 0);
        chk("lu_bub1_b", b_valid, 0);
        chk("lu_stall2_a", a_stall, 0);
        chk("lu_stall2_b", b_stall, 1);
        @(posedge clk); #1;
        chk("lu_cap_a", a_valid, 1);
        chk("lu_cap_rd", a_rd, 8);
        chk("lu_cap_d2", a_d2, 32'h77);
        chk("lu_bub2_b", b_valid, 0);
        chk("lu_stall3_b", b_stall, 0);
        @(posedge clk); #1;
        chk("lu_cap_b", b_valid, 1);
        chk("lu_cnt_a", a_cnt, 1);
        chk("lu_cnt_b", b_cnt, 2);

        // Flush together with hold and a load-use hit.
        @(negedge clk); drive_load(5'd7);
        @(posedge clk);
        @(negedge clk); drive_use(5'd7, 1'b1); hold_ex = 1; flush = 1;
        #1 chk("fl_stall_a", a_stall, 1);
        @(posedge clk); #1;
        chk("fl_valid_a", a_valid, 0);
        chk("fl_flags_a", {a_rw, a_dw, a_mr}, 0);
        chk("fl_valid_b", b_valid, 0);
        chk("fl_cnt_a", a_cnt, 1);
        chk("fl_cnt_b", b_cnt, 2);
        @(negedge clk); hold_ex = 0; flush = 0;
        #1 chk("fl_post_a", a_stall, 0);
        chk("fl_post_b", b_stall, 0);

        // Twenty load-use hazards via rs1: A reaches 21, B saturates at 15.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); drive_load(5'd7);
            @(posedge clk);
            @(negedge clk); drive_use(5'd7, 1'b0);
            repeat (3) @(posedge clk);
        end
        @(negedge clk);
        chk("sat_cnt_a", a_cnt, 21);
        chk("sat_cnt_b", b_cnt, 15);
        chk("sat_valid_a", a_valid, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised successor to the decode-stage pipeline register: captures decoded operands and control into the ID/EX boundary.
- Adds async reset, valid tracking, flush and downstream hold.
- Adds load-use interlock with a configurable bubble count, WB-to-ID register-file bypass, and a saturating stall counter.
- Sits between decode logic (control unit, immediate unit, register file) and the execute stage.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.
- CTRL_W, 16, width of the opaque control bundle (alu_op, bu_op, dm_ctrl, write_src, operand selects) passed through unchanged.
- LU_BUBBLES, 1, bubbles inserted per load-use hazard (1..3).
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- valid_de  in  1  decode slot holds a real instruction.
- pc_de, pc_next_de  in  XLEN  PC and PC+4 of the decoding instruction.
- rs1_de, rs2_de, rd_de  in  RA_W  register fields.
- use_rs1_de, use_rs2_de  in  1  instruction actually reads rs1/rs2.
- ru_rs1_de, ru_rs2_de  in  XLEN  register-file read data.
- imm_de  in  XLEN  extended immediate.
- ctrl_de  in  CTRL_W  control bundle.
- ru_write_de, dm_wr_de, mem_rd_de  in  1  register write, store, and load flags.
- dw_wb  in  XLEN  writeback data.
- rd_wb  in  RA_W  writeback destination.
- ru_we_wb  in  1  writeback enable.
- hold_ex  in  1  execute stage cannot accept; freeze ID/EX.
- flush  in  1  taken branch/jump; kill the slot entering EX.
- valid_ex  out  1  EX slot valid.
- pc_ex, pc_next_ex, rs1_data_ex, rs2_data_ex, imm_ex  out  XLEN  registered copies.
- rs1_ex, rs2_ex, rd_ex  out  RA_W  registered register fields.
- ctrl_ex  out  CTRL_W  registered control bundle.
- ru_write_ex, dm_wr_ex, mem_rd_ex  out  1  registered flags, qualified by valid.
- stall_fd  out  1  combinational; freeze PC and IF/ID.
- stall_cnt  out  CNT_W  count of interlock stall cycles.

Behaviour:
- Reset (async, active-high): every output register goes to 0, including valid_ex, ru_write_ex, dm_wr_ex and mem_rd_ex. Bubble counter goes to 0 and stall_cnt goes to 0. Release takes effect on the next rising edge.
- Bypass (combinational, before capture):
  - rs1_byp = dw_wb when ru_we_wb && rd_wb==rs1_de && rd_wb!=0; otherwise ru_rs1_de.
  - rs2_byp is formed the same way from rs2_de and ru_rs2_de.
  - x0 is never bypassed.
- Hazard detection:
  - lu_hit = valid_ex && mem_rd_ex && rd_ex!=0 && valid_de && ((use_rs1_de && rs1_de==rd_ex) || (use_rs2_de && rs2_de==rd_ex)).
- Bubble counter (0..LU_BUBBLES-1):
  - On lu_hit with count 0 and no flush/hold, load LU_BUBBLES-1.
  - Decrement each cycle while nonzero and not hold_ex.
  - Cleared by flush.
- stall_fd = hold_ex || (lu_hit && !flush) || cnt!=0.
- Register update priority per rising edge:
  1. flush: valid_ex=0 and all three flags=0; other fields don't care (implementation clears them to 0).
  2. hold_ex: all ID/EX registers keep their value.
  3. lu_hit or cnt!=0: insert bubble (valid_ex=0, flags=0); decode inputs are held upstream by stall_fd.
  4. Otherwise capture: valid_ex=valid_de; flags = flag_de && valid_de; data fields take the _de / _byp values.
- Latency: 1 cycle from decode to EX outputs.
- A load-use hazard costs exactly LU_BUBBLES bubbles.
- stall_cnt increments by 1 on every cycle with lu_hit||cnt!=0 and no flush. It saturates at all-ones and never wraps. hold_ex-only cycles are not counted.
- Simultaneous flush and hold_ex: flush wins.
- Simultaneous flush and lu_hit: no bubble count started; stall_fd follows hold_ex only.
- Write to x0 is never flagged as a hazard.

Decomposition:
- Package pipe_pkg holds:
  - XLEN and RA_W defaults;
  - a ctrl_t packed struct (alu_op[3:0], bu_op[4:0], dm_ctrl[2:0], write_src[1:0], alu_a_src, alu_b_src) whose width defines CTRL_W;
  - a function is_bypass(rd, rs, we).
- Sub-module hazard_unit:
  - contains the lu_hit compare, bubble counter and stall_fd;
  - decode_stage_pipe holds the registers, bypass muxes and stall_cnt.

Test Plan:
- Reset pulse mid-capture with valid_de=1 and pc_de=0x40 -> all outputs 0 immediately, valid_ex=0, stall_cnt=0.
- Plain ADD: rs1=3, rs2=4, pc_de=0x100, no hazards -> next edge valid_ex=1, pc_ex=0x100, rs1_ex=3, ru_write_ex=1, stall_fd=0.
- Bypass: rd_wb=5, ru_we_wb=1, dw_wb=0xDEADBEEF, rs1_de=5, ru_rs1_de=0 -> rs1_data_ex=0xDEADBEEF. With rd_wb=0, rs1_de=0 -> rs1_data_ex=ru_rs1_de.
- Load-use: EX holds load rd=7; decode reads rs2=7 with use_rs2_de=1.
  - LU_BUBBLES=1 -> one stall_fd cycle, one bubble (valid_ex=0), then capture; stall_cnt=1.
  - LU_BUBBLES=2 -> two bubbles, stall_cnt=2.
- Flush coinciding with hold_ex and lu_hit -> valid_ex=0 next edge, counter 0, stall_cnt unchanged.
- Saturation: CNT_W=4, 20 consecutive load-use stalls -> stall_cnt stops at 15.
